seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed 7-segment scan driver.
// A single-clock prescaler steps through NUM_DIGITS slots. Each slot begins with
// a guard interval in which all selects are off, which suppresses ghosting while
// the segment lines settle. Inputs are snapshotted at the start of every frame,
// so changes made mid-frame never tear the displayed frame.
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYC    = 2,
  parameter int BLINK_FRAMES = 83
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [7:0]              seg_l,
  output logic [7:0]              seg_h,
  output logic                    frame_start,
  output logic                    blink_phase
);

  localparam int IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRESC_W-1:0]      presc;
  logic [IDX_W-1:0]        idx;
  logic [BLINK_W-1:0]      blink_cnt;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [NUM_DIGITS-1:0]   snap_dp;

  logic                    frame_edge;
  logic                    presc_wrap;
  logic                    idx_last;
  logic                    in_guard;

  logic [4*NUM_DIGITS-1:0] cur_digits;
  logic [NUM_DIGITS-1:0]   cur_blink;
  logic [NUM_DIGITS-1:0]   cur_blank;
  logic [NUM_DIGITS-1:0]   cur_dp;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              nibble;
  logic [7:0]              seg_val;

  assign frame_edge = (presc == '0) && (idx == '0);
  assign presc_wrap = (presc == PRESC_W'(SCAN_DIV - 1));
  assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));

  generate
    if (GUARD_CYC == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (presc < PRESC_W'(GUARD_CYC));
    end
  endgenerate

  // On the frame-start cycle the snapshot is being loaded on this same edge, so
  // decode from the live inputs; that is exactly the value being captured.
  assign cur_digits = frame_edge ? digits     : snap_digits;
  assign cur_blink  = frame_edge ? blink_mask : snap_blink;
  assign cur_blank  = frame_edge ? blank_mask : snap_blank;
  assign cur_dp     = frame_edge ? dp_mask    : snap_dp;

  assign nibble = cur_digits[idx*4 +: 4];

  // Segment patterns {a,b,c,d,e,f,g,dp}; the dp bit is supplied separately.
  function automatic logic [7:0] hex_pattern(input logic [3:0] n);
    case (n)
      4'h0:    hex_pattern = 8'hFC;
      4'h1:    hex_pattern = 8'h60;
      4'h2:    hex_pattern = 8'hDA;
      4'h3:    hex_pattern = 8'hF2;
      4'h4:    hex_pattern = 8'h66;
      4'h5:    hex_pattern = 8'hB6;
      4'h6:    hex_pattern = 8'hBE;
      4'h7:    hex_pattern = 8'hE0;
      4'h8:    hex_pattern = 8'hFE;
      4'h9:    hex_pattern = 8'hF6;
      4'hA:    hex_pattern = 8'hEE;
      4'hB:    hex_pattern = 8'h3E;
      4'hC:    hex_pattern = 8'h9C;
      4'hD:    hex_pattern = 8'h7A;
      4'hE:    hex_pattern = 8'h9E;
      default: hex_pattern = 8'h8E;
    endcase
  endfunction

`ifdef SEG_SCAN_LZB_EN
  // Leading zeros, scanned from the most significant digit down; digit 0 always shows.
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (cur_digits[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lz_blank[i] = ~seen_nz;
    end
  end
`else
  // Leading-zero blanking is not built in; zeros display as 0.
  always_comb begin
    lz_blank = '0;
  end
`endif

  // Segment value for the current slot: blank beats blink, and blink beats decode.
  always_comb begin
    seg_val = {hex_pattern(nibble)[7:1], cur_dp[idx]};
    if (lz_blank[idx]) seg_val[7:1] = 7'h00;
    if (cur_blank[idx]) begin
      seg_val = 8'h00;
    end else if (cur_blink[idx] && blink_phase) begin
      seg_val = 8'h00;
    end
  end

  // Prescaler, digit index, blink frame counter and the per-frame input snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_blink  <= '0;
      snap_blank  <= '0;
      snap_dp     <= '0;
    end else begin
      if (frame_edge) begin
        snap_digits <= digits;
        snap_blink  <= blink_mask;
        snap_blank  <= blank_mask;
        snap_dp     <= dp_mask;
      end
      if (presc_wrap) begin
        presc <= '0;
        if (idx_last) begin
          idx <= '0;
          if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Registered pin outputs, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel         <= '0;
      seg_l       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_edge;
      if (in_guard) begin
        sel   <= '0;
        seg_l <= '0;
      end else begin
        sel   <= NUM_DIGITS'(1) << idx;
        seg_l <= seg_val;
      end
    end
  end

  assign seg_h = seg_l;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1,
// BLINK_FRAMES=2. Expected segment codes are hand-computed per frame.
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  sel;
  logic [7:0]  seg_l;
  logic [7:0]  seg_h;
  logic        frame_start;
  logic        blink_phase;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] pend_digits;
  logic [3:0]  pend_blink;
  logic [3:0]  pend_blank;
  logic [3:0]  pend_dp;

  seg_scan_mux #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .GUARD_CYC   (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blink_mask (blink_mask),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .sel        (sel),
    .seg_l      (seg_l),
    .seg_h      (seg_h),
    .frame_start(frame_start),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One frame (or its first nsteps output cycles). e packs {d3,d2,d1,d0} codes.
  // At output step chg_at the pending inputs are applied.
  task automatic run_frame(input string tag, input logic [31:0] e, input logic ph,
                           input int nsteps, input int chg_at);
    int         slot;
    int         p;
    logic [3:0] esel;
    logic [7:0] eseg;
    for (int k = 0; k < nsteps; k++) begin
      slot = k / 4;
      p    = k % 4;
      @(posedge clk);
      #1;
      esel = (p == 0) ? 4'b0000 : (4'b0001 << slot);
      eseg = (p == 0) ? 8'h00 : e[slot*8 +: 8];
      check_val($sformatf("%s_sel_%0d", tag, k), 32'(sel), 32'(esel));
      check_val($sformatf("%s_segl_%0d", tag, k), 32'(seg_l), 32'(eseg));
      check_val($sformatf("%s_segh_%0d", tag, k), 32'(seg_h), 32'(eseg));
      check_val($sformatf("%s_fs_%0d", tag, k), 32'(frame_start), 32'(k == 0));
      if (k == 8) check_val($sformatf("%s_phase", tag), 32'(blink_phase), 32'(ph));
      if (k == chg_at) begin
        digits     = pend_digits;
        blink_mask = pend_blink;
        blank_mask = pend_blank;
        dp_mask    = pend_dp;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_sel"},   32'(sel),         32'h0);
    check_val({tag, "_segl"},  32'(seg_l),       32'h0);
    check_val({tag, "_segh"},  32'(seg_h),       32'h0);
    check_val({tag, "_fs"},    32'(frame_start), 32'h0);
    check_val({tag, "_phase"}, 32'(blink_phase), 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    digits     = 16'h1234;
    blink_mask = 4'b0000;
    blank_mask = 4'b0000;
    dp_mask    = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;

    // 1234: digit0=4, digit1=3, digit2=2, digit3=1
    run_frame("f1", {8'h60, 8'hDA, 8'hF2, 8'h66}, 1'b0, 16, -1);

    // Mid-frame change during idx=2 must not tear this frame.
    pend_digits = 16'h5678;
    pend_blink  = 4'b0011;
    pend_blank  = 4'b0000;
    pend_dp     = 4'b0000;
    run_frame("f2", {8'h60, 8'hDA, 8'hF2, 8'h66}, 1'b0, 16, 9);

    // 5678 with digits 0,1 blinking: off phase for two frames, then on for two.
    run_frame("f3", {8'hB6, 8'hBE, 8'h00, 8'h00}, 1'b1, 16, -1);
    run_frame("f4", {8'hB6, 8'hBE, 8'h00, 8'h00}, 1'b1, 16, -1);
    run_frame("f5", {8'hB6, 8'hBE, 8'hE0, 8'hFE}, 1'b0, 16, -1);

    pend_digits = 16'hF0A9;
    pend_blink  = 4'b0000;
    pend_blank  = 4'b1000;
    pend_dp     = 4'b0100;
    run_frame("f6", {8'hB6, 8'hBE, 8'hE0, 8'hFE}, 1'b0, 16, 9);

    // F0A9: digit3 blanked (select still on), digit2 = 0 with dp, A, 9
    run_frame("f7", {8'h00, 8'hFD, 8'hEE, 8'hF6}, 1'b1, 16, -1);

    // Reset sampled at the edge that processes idx=2, presc=2.
    run_frame("f8", {8'h00, 8'hFD, 8'hEE, 8'hF6}, 1'b1, 10, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    run_frame("r1", {8'h00, 8'hFD, 8'hEE, 8'hF6}, 1'b0, 16, -1);

    digits     = 16'h0070;
    blank_mask = 4'b0000;
    dp_mask    = 4'b0000;
`ifdef SEG_SCAN_LZB_EN
    run_frame("z1", {8'h00, 8'h00, 8'hE0, 8'hFC}, 1'b0, 16, -1);
`else
    run_frame("z1", {8'hFC, 8'hFC, 8'hE0, 8'hFC}, 1'b0, 16, -1);
`endif

    digits = 16'h0000;
`ifdef SEG_SCAN_LZB_EN
    run_frame("z2", {8'h00, 8'h00, 8'h00, 8'hFC}, 1'b1, 16, -1);
`else
    run_frame("z2", {8'hFC, 8'hFC, 8'hFC, 8'hFC}, 1'b1, 16, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
